// File: rtl/cdc_multi_sync.sv
// cdc_multi_sync: per-channel multi-flop synchroniser with optional glitch
// filter and single-cycle edge detection on the synchronised level.
//
// Optional feature: define CDC_MULTI_SYNC_FILTER_EN to compile in the
// per-channel glitch filter (FILT_CYC honoured). Undefined: sync_o is the
// last synchroniser stage and FILT_CYC is ignored.
//
// Ports:
//   clk      in   1      destination-domain clock
//   nreset   in   1      asynchronous active-low reset
//   async_i  in   WIDTH  asynchronous level inputs, one per channel
//   sync_o   out  WIDTH  synchronised (optionally filtered) levels
//   rise_o   out  WIDTH  one-cycle pulse on sync_o 0->1
//   fall_o   out  WIDTH  one-cycle pulse on sync_o 1->0
//   chg_o    out  1      OR of all rise_o / fall_o bits
module cdc_multi_sync #(
    parameter int unsigned       WIDTH    = 4,
    parameter int unsigned       STAGES   = 2,
    parameter logic [WIDTH-1:0]  RST_VAL  = {WIDTH{1'b0}},
    parameter int unsigned       FILT_CYC = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             chg_o
);

    // Elaboration-time parameter range checks
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cdc_multi_sync: WIDTH out of range 1..32");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("cdc_multi_sync: STAGES out of range 2..4");
    end
    if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt
        $error("cdc_multi_sync: FILT_CYC out of range 1..255");
    end

    logic [STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]             r_hist;
    logic [WIDTH-1:0]             w_last;
    logic [WIDTH-1:0]             w_level;

    // Synchroniser chain: stage 0 samples async_i directly, no logic between stages
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync[0] <= async_i;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_last = r_sync[STAGES-1];

`ifdef CDC_MULTI_SYNC_FILTER_EN
    localparam int unsigned        CNT_W    = $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]            r_filt;

    // Glitch filter: accept a new level only after FILT_CYC consecutive
    // mismatching cycles. The counter clears on acceptance, so it never
    // climbs past CNT_LAST and cannot wrap.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt  <= '0;
            r_filt <= RST_VAL;
        end else begin
            for (int n = 0; n < WIDTH; n++) begin
                if (w_last[n] == r_filt[n]) begin
                    r_cnt[n] <= '0;
                end else if (r_cnt[n] == CNT_LAST) begin
                    r_filt[n] <= w_last[n];
                    r_cnt[n]  <= '0;
                end else begin
                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_last;
`endif

    // Previous-cycle copy of the output level for edge detection
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_hist <= RST_VAL;
        end else begin
            r_hist <= w_level;
        end
    end

    // Pulses derive from two registers so they coincide with the first
    // cycle the new level is visible on sync_o.
    assign sync_o = w_level;
    assign rise_o = w_level & ~r_hist;
    assign fall_o = ~w_level & r_hist;
    assign chg_o  = |(w_level ^ r_hist);

endmodule

// File: tb/tb_cdc_multi_sync.sv
// tb_cdc_multi_sync: randomized and directed stimulus on three instances
// of cdc_multi_sync, checked against a sample-history reference model.
// The model states the behaviour directly: the unfiltered level is the input
// sampled STAGES-1 edges earlier; the filtered level takes value v once the
// last FILT_CYC unfiltered samples all equal v, and holds otherwise.
module tb_cdc_multi_sync;

    localparam int NDUT = 3;
    localparam int HMAX = 4096;
    localparam int        ST [NDUT] = '{2, 3, 2};
    localparam logic [3:0] RV [NDUT] = '{4'h0, 4'hF, 4'h0};
    localparam int        FC [NDUT] = '{4, 4, 255};
`ifdef CDC_MULTI_SYNC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nreset;
    logic [3:0] in_v [NDUT];
    logic [3:0] so   [NDUT];
    logic [3:0] ro   [NDUT];
    logic [3:0] fo   [NDUT];
    logic       co   [NDUT];

    cdc_multi_sync #(.WIDTH(4), .STAGES(ST[0]), .RST_VAL(RV[0]), .FILT_CYC(FC[0])) u_dut0 (
        .clk(clk), .nreset(nreset), .async_i(in_v[0]),
        .sync_o(so[0]), .rise_o(ro[0]), .fall_o(fo[0]), .chg_o(co[0]));
    cdc_multi_sync #(.WIDTH(4), .STAGES(ST[1]), .RST_VAL(RV[1]), .FILT_CYC(FC[1])) u_dut1 (
        .clk(clk), .nreset(nreset), .async_i(in_v[1]),
        .sync_o(so[1]), .rise_o(ro[1]), .fall_o(fo[1]), .chg_o(co[1]));
    cdc_multi_sync #(.WIDTH(4), .STAGES(ST[2]), .RST_VAL(RV[2]), .FILT_CYC(FC[2])) u_dut2 (
        .clk(clk), .nreset(nreset), .async_i(in_v[2]),
        .sync_o(so[2]), .rise_o(ro[2]), .fall_o(fo[2]), .chg_o(co[2]));

    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    logic [3:0] hist   [NDUT][HMAX];
    int         nedge  [NDUT];
    logic [3:0] m_sync [NDUT];
    logic [3:0] m_prev [NDUT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Unfiltered level after the j-th edge since reset release
    function automatic logic [3:0] dsamp(input int k, input int j);
        int idx;
        idx = j - ST[k] + 1;
        if (idx >= 1) return hist[k][idx-1];
        return RV[k];
    endfunction

    task automatic model_edge(input int k);
        logic [3:0] cur;
        logic [3:0] s;
        logic       v;
        bit         all_eq;
        cur = dsamp(k, nedge[k]);
        if (!FILT) begin
            m_sync[k] = cur;
        end else begin
            for (int b = 0; b < 4; b++) begin
                v = cur[b];
                all_eq = 1'b1;
                for (int j = nedge[k] - FC[k] + 1; j <= nedge[k]; j++) begin
                    s = dsamp(k, j);
                    if (s[b] !== v) all_eq = 1'b0;
                end
                if (all_eq) m_sync[k][b] = v;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            nedge[k]  = 0;
            m_sync[k] = RV[k];
            m_prev[k] = RV[k];
        end
    endtask

    task automatic step();
        logic [3:0] er;
        logic [3:0] ef;
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (nedge[k] < HMAX) begin
                hist[k][nedge[k]] = in_v[k];
                nedge[k]++;
            end
            model_edge(k);
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            er = m_sync[k] & ~m_prev[k];
            ef = ~m_sync[k] & m_prev[k];
            check($sformatf("sync%0d", k), 32'(so[k]), 32'(m_sync[k]));
            check($sformatf("rise%0d", k), 32'(ro[k]), 32'(er));
            check($sformatf("fall%0d", k), 32'(fo[k]), 32'(ef));
            check($sformatf("chg%0d", k),  32'(co[k]), 32'(|(er | ef)));
            m_prev[k] = m_sync[k];
        end
    endtask

    task automatic reset_check();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_sync%0d", k), 32'(so[k]), 32'(RV[k]));
            check($sformatf("rst_rise%0d", k), 32'(ro[k]), 32'h0);
            check($sformatf("rst_fall%0d", k), 32'(fo[k]), 32'h0);
            check($sformatf("rst_chg%0d", k),  32'(co[k]), 32'h0);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        nreset = 1'b0;
        in_v[0] = 4'h0;
        in_v[1] = 4'hF;
        in_v[2] = 4'h0;
        model_reset();
        #12;
        reset_check();
        @(posedge clk);
        #2 nreset = 1'b1;

        // Reset release with inputs equal to reset value, then 0000->0101 on dut0
        repeat (8) step();
        in_v[0] = 4'b0101;
        step();
        step();
`ifndef CDC_MULTI_SYNC_FILTER_EN
        check("d029_sync", 32'(so[0]), 32'h5);
        check("d029_rise", 32'(ro[0]), 32'h5);
        check("d029_chg",  32'(co[0]), 32'h1);
        step();
        check("d029_rise_end", 32'(ro[0]), 32'h0);
        check("d029_chg_end",  32'(co[0]), 32'h0);
`endif
        repeat (10) step();

        // Simultaneous multi-channel rise and fall
        in_v[0] = 4'b0100;
        repeat (12) step();
        in_v[0] = 4'b1010;
        repeat (12) step();

        // Short and long pulses on channel 0
        in_v[0] = 4'b0000;
        repeat (12) step();
        in_v[0] = 4'b0001;
        repeat (3) step();
        in_v[0] = 4'b0000;
        repeat (12) step();
        in_v[0] = 4'b0001;
        repeat (6) step();
        in_v[0] = 4'b0000;
        repeat (12) step();

        // Reset in the middle of a pending filtered change
        in_v[0] = 4'hF;
        repeat (4) step();
        #2 nreset = 1'b0;
        #1 reset_check();
        model_reset();
        @(posedge clk);
        #2 nreset = 1'b1;
        repeat (12) step();

        // Long hold against a 255-cycle filter
        in_v[2] = 4'b0001;
        repeat (300) step();

        // Randomized levels with random hold lengths
        repeat (500) begin
            for (int k = 0; k < NDUT; k++) begin
                if ($urandom_range(0, 3) == 0) in_v[k] = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_multi_sync.md
CDC_MULTI_SYNC -- requirements
Module: cdc_multi_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, number of independent single-bit channels (1..32).
REQ-002 The block SHALL have parameter STAGES, default 2, synchroniser flop depth per channel (2..4).
REQ-003 The block SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, per-channel reset value of all synchroniser, filter and output state.
REQ-004 The block SHALL have parameter FILT_CYC, default 4, consecutive stable cycles required by the glitch filter (1..255).
REQ-005 The block SHALL have port clk  input  1  destination-domain clock.
REQ-006 The block SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port async_i  input  WIDTH  asynchronous level inputs, one per channel.
REQ-008 The block SHALL have port sync_o  output  WIDTH  synchronised (optionally filtered) levels.
REQ-009 The block SHALL have port rise_o  output  WIDTH  one-cycle pulse per channel on sync_o 0->1.
REQ-010 The block SHALL have port fall_o  output  WIDTH  one-cycle pulse per channel on sync_o 1->0.
REQ-011 The block SHALL have port chg_o  output  1  OR of all rise_o and fall_o bits.

Function
REQ-012 Each channel SHALL pass async_i[n] through a chain of STAGES flops clocked by clk; no logic between stages; stage 0 input is async_i[n] directly.
REQ-013 Channels SHALL be fully independent; no cross-channel coherency is guaranteed (single-bit semantics only).
REQ-014 Without filter, a level stable on async_i[n] before clk edge k SHALL appear on sync_o[n] after edge k+STAGES-1 (latency STAGES cycles, +1 possible from metastability resolution).
REQ-015 Filter, per channel: counter of width clog2(FILT_CYC+1); when last sync stage != sync_o[n], counter increments each cycle; when counter == FILT_CYC-1 and mismatch persists, sync_o[n] takes the new value and counter clears.
REQ-016 Filter: any cycle with last sync stage == sync_o[n] SHALL clear the counter; a pulse shorter than FILT_CYC cycles at the last sync stage SHALL never reach sync_o.
REQ-017 Filter latency SHALL be STAGES+FILT_CYC cycles from stable input to sync_o; FILT_CYC=1 gives STAGES+1.
REQ-018 Counter SHALL saturate, never wrap; at FILT_CYC=255 the counter is 8 bits and SHALL not overflow.
REQ-019 Edge history: a per-channel register holding sync_o of the previous cycle; rise_o[n] = sync_o[n] & ~hist[n], fall_o[n] = ~sync_o[n] & hist[n].
REQ-020 rise_o/fall_o SHALL be high exactly in the first cycle sync_o shows the new level, for exactly one cycle; rise_o[n] and fall_o[n] SHALL never be high together.
REQ-021 Toggling input faster than the pipeline resolves SHALL yield alternating rise/fall pulses, never a missing alternation at sync_o (each sync_o change produces exactly one pulse).
REQ-022 chg_o SHALL be high in any cycle where any rise_o or fall_o bit is high, simultaneous multi-channel edges included.

Reset
REQ-023 nreset low SHALL asynchronously force every sync stage, sync_o and edge history to RST_VAL, counters to 0, rise_o/fall_o/chg_o to 0.
REQ-024 Every flop in the block SHALL be reset; no unreset storage is permitted.
REQ-025 Reset release SHALL produce no edge pulse unless async_i differs from RST_VAL, in which case exactly one pulse per differing channel follows after the normal latency.
REQ-026 Reset asserted mid-filter-count SHALL discard the pending change; counting restarts from 0 after release.

Configuration
REQ-027 Macro CDC_MULTI_SYNC_FILTER_EN defined: glitch filter per REQ-015..018 is compiled in and FILT_CYC is honoured.
REQ-028 Macro CDC_MULTI_SYNC_FILTER_EN undefined: no counters exist, sync_o is the last sync stage, FILT_CYC is ignored, latency per REQ-014.

Verification
REQ-029 WIDTH=4, STAGES=2, no filter: async_i 0000->0101 before edge 10 -> sync_o=0101 after edge 11; rise_o=0101 and chg_o=1 for exactly that cycle.
REQ-030 STAGES=3, RST_VAL=4'b1111, async_i=1111 held through reset release -> sync_o=1111 and no rise/fall/chg pulse in 20 cycles.
REQ-031 Filter, FILT_CYC=4: 3-cycle high pulse on async_i[0] -> sync_o[0] stays 0, no pulse; 6-cycle pulse -> sync_o[0] high after STAGES+4 cycles, one rise then one fall.
REQ-032 Filter: nreset asserted at counter=2 of a pending change -> all outputs RST_VAL/0 immediately; after release change re-qualifies in full STAGES+FILT_CYC cycles.
REQ-033 Channels 1 and 3 rise and channel 2 falls on the same edge -> rise_o=1010, fall_o=0100, chg_o high one cycle.
REQ-034 FILT_CYC=255, input held changed 300 cycles -> single update at cycle STAGES+255, counter never wraps, no second pulse.
